// File: rtl/stream_mux_n_to_1.sv
// ---------------------------------------------------------------------------
// stream_mux_n_to_1
//
// N-channel, W-bit stream multiplexer with per-channel valid/ready handshakes
// and a one-word registered output stage. Two arbitration modes:
//   mode_i = 0 : fixed select, channel sel_i is granted when it is valid
//   mode_i = 1 : round-robin, scanning from rr_ptr upwards modulo N
//
// Parameters
//   N      number of input channels (2..16)
//   W      data width per channel
//   SEL_W  channel index width, N <= 2**SEL_W
//   CNT_W  width of the accepted-word counter
//
// Ports
//   clk           single clock, rising-edge active
//   rst_n         asynchronous active-low reset
//   mode_i        arbitration mode (0 fixed, 1 round-robin)
//   sel_i         channel index used in fixed mode
//   in_data_i     channel k data at bits [k*W+W-1 : k*W]
//   in_valid_i    per-channel valid
//   in_ready_o    per-channel ready (combinational, at most one bit set)
//   out_data_o    registered output word
//   out_src_o     channel index of the word in out_data_o
//   out_valid_o   registered output valid
//   out_ready_i   consumer ready
//   xfer_count_o  words accepted from the inputs since reset (wrapping)
// ---------------------------------------------------------------------------
module stream_mux_n_to_1 #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int SEL_W = 2,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode_i,
  input  logic [SEL_W-1:0]   sel_i,
  input  logic [N*W-1:0]     in_data_i,
  input  logic [N-1:0]       in_valid_i,
  output logic [N-1:0]       in_ready_o,
  output logic [W-1:0]       out_data_o,
  output logic [SEL_W-1:0]   out_src_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [CNT_W-1:0]   xfer_count_o
);

  // Registered state
  logic               run_q;
  logic [W-1:0]       out_data_q,   out_data_d;
  logic [SEL_W-1:0]   out_src_q,    out_src_d;
  logic               out_valid_q,  out_valid_d;
  logic [CNT_W-1:0]   xfer_count_q, xfer_count_d;
  logic [SEL_W-1:0]   rr_ptr_q,     rr_ptr_d;

  // Combinational arbitration signals
  logic [N-1:0]       rot_valid_s;
  int                 rr_off_s;
  int                 rr_idx_s;
  logic               rr_valid_s;
  logic               fixed_valid_s;
  int                 fixed_idx_s;
  logic               grant_valid_s;
  int                 grant_idx_s;
  logic [W-1:0]       grant_data_s;
  logic               load_en_s;
  logic [N-1:0]       in_ready_s;
  logic               xfer_s;
  int                 rr_next_s;

  // Reset-release register: asserts with rst_n, releases one edge after
  // deassertion so no handshake can fire on the edge that ends reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // Grant computation for both arbitration modes
  always_comb begin
    rot_valid_s   = '0;
    rr_off_s      = 0;
    rr_idx_s      = 0;
    rr_valid_s    = 1'b0;
    fixed_valid_s = 1'b0;
    fixed_idx_s   = int'(sel_i);
    grant_valid_s = 1'b0;
    grant_idx_s   = 0;

    // rot_valid_s[j] is the valid of channel (rr_ptr + j) mod N; only
    // constant bit-selects are used so no index ever leaves the vector.
    for (int j = 0; j < N; j++) begin
      for (int k = 0; k < N; k++) begin
        rot_valid_s[j] = rot_valid_s[j] |
                         ((((int'(rr_ptr_q) + j) % N) == k) && in_valid_i[k]);
      end
    end

    // Lowest rotated position wins: scan downward so the last write is the
    // first set bit.
    for (int j = N - 1; j >= 0; j--) begin
      rr_off_s = rot_valid_s[j] ? j : rr_off_s;
    end
    rr_valid_s = |rot_valid_s;
    rr_idx_s   = int'(rr_ptr_q) + rr_off_s;
    rr_idx_s   = (rr_idx_s >= N) ? (rr_idx_s - N) : rr_idx_s;

    // An out-of-range sel matches no k, so it can never grant.
    for (int k = 0; k < N; k++) begin
      fixed_valid_s = fixed_valid_s | ((int'(sel_i) == k) && in_valid_i[k]);
    end

    if (mode_i) begin
      grant_valid_s = rr_valid_s;
      grant_idx_s   = rr_idx_s;
    end else begin
      grant_valid_s = fixed_valid_s;
      grant_idx_s   = fixed_idx_s;
    end
  end

  // Handshake generation and granted-data selection
  always_comb begin
    load_en_s    = ~out_valid_q | out_ready_i;
    in_ready_s   = '0;
    grant_data_s = '0;
    for (int k = 0; k < N; k++) begin
      in_ready_s[k] = run_q & load_en_s & grant_valid_s & (grant_idx_s == k);
      grant_data_s  = (grant_idx_s == k) ? in_data_i[k*W +: W] : grant_data_s;
    end
    xfer_s = |(in_ready_s & in_valid_i);
  end

  assign in_ready_o = in_ready_s;

  // Next-state logic for the output stage, counter and round-robin pointer
  always_comb begin
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    out_valid_d  = out_valid_q;
    xfer_count_d = xfer_count_q;
    rr_ptr_d     = rr_ptr_q;
    rr_next_s    = grant_idx_s + 1;
    rr_next_s    = (rr_next_s == N) ? 0 : rr_next_s;

    if (xfer_s) begin
      // Covers both an empty register and drain-plus-load in one edge.
      out_data_d   = grant_data_s;
      out_src_d    = SEL_W'(grant_idx_s);
      out_valid_d  = 1'b1;
      xfer_count_d = xfer_count_q + CNT_W'(1);
      if (mode_i) begin
        rr_ptr_d = SEL_W'(rr_next_s);
      end else begin
        rr_ptr_d = rr_ptr_q;
      end
    end else if (out_valid_q && out_ready_i) begin
      // Drain only: data and source keep their last values.
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output stage, counter and pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q   <= '0;
      out_src_q    <= '0;
      out_valid_q  <= 1'b0;
      xfer_count_q <= '0;
      rr_ptr_q     <= '0;
    end else begin
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      out_valid_q  <= out_valid_d;
      xfer_count_q <= xfer_count_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign out_data_o   = out_data_q;
  assign out_src_o    = out_src_q;
  assign out_valid_o  = out_valid_q;
  assign xfer_count_o = xfer_count_q;

endmodule

// File: tb/tb_stream_mux_n_to_1.sv
module tb_stream_mux_n_to_1;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             mode;
  logic [SEL_W-1:0] sel;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic [W-1:0]     out_data;
  logic [SEL_W-1:0] out_src;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] xfer_count;

  typedef struct packed {
    logic [W-1:0]     d;
    logic [SEL_W-1:0] s;
  } exp_t;

  exp_t sb_q[$];
  int   n_total;
  int   n_pass;

  stream_mux_n_to_1 #(.N(N), .W(W), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode_i       (mode),
    .sel_i        (sel),
    .in_data_i    (in_data),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .out_data_o   (out_data),
    .out_src_o    (out_src),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .xfer_count_o (xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] d, input logic [SEL_W-1:0] s);
    exp_t e;
    e.d = d;
    e.s = s;
    sb_q.push_back(e);
  endtask

  // advance past the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // wait for the falling edge (inputs stable, away from active edge)
  task automatic settle();
    @(negedge clk);
  endtask

  // Monitor: every word accepted by the consumer is popped and compared
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_word", {24'h0, out_data}, 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          check("sb_out_data", {24'h0, out_data}, {24'h0, e.d});
          check("sb_out_src",  {29'h0, out_src},  {29'h0, e.s});
        end
      end
    end
  end

  initial begin
    n_total   = 0;
    n_pass    = 0;
    rst_n     = 1'b1;
    mode      = 1'b0;
    sel       = 3'd0;
    in_data   = 32'h0;
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    #2;
    rst_n    = 1'b0;
    mode     = 1'b1;
    in_valid = 4'b1111;
    #10;
    check("rst_out_valid",  {31'h0, out_valid},  32'h0);
    check("rst_out_data",   {24'h0, out_data},   32'h0);
    check("rst_out_src",    {29'h0, out_src},    32'h0);
    check("rst_xfer_count", {28'h0, xfer_count}, 32'h0);
    check("rst_in_ready",   {28'h0, in_ready},   32'h0);
    cyc();
    cyc();

    // Test 1: fixed select, sel=2, all valid
    rst_n     = 1'b1;
    mode      = 1'b0;
    sel       = 3'd2;
    in_valid  = 4'b1111;
    in_data   = {8'h04, 8'hA5, 8'h02, 8'h01};
    out_ready = 1'b1;
    settle();
    check("t1_ready_before_release_edge", {28'h0, in_ready}, 32'h0);
    cyc();
    settle();
    check("t1_in_ready", {28'h0, in_ready}, 32'h4);
    push(8'hA5, 3'd2);
    cyc();
    in_valid = 4'b0000;
    settle();
    check("t1_out_valid", {31'h0, out_valid},  32'h1);
    check("t1_xfer",      {28'h0, xfer_count}, 32'd1);
    cyc();

    // Test 2: round-robin, all valid, 8 transfers
    mode     = 1'b1;
    in_valid = 4'b1111;
    in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int i = 0; i < 8; i++) begin
      push(W'(8'h10 + (i % 4)), SEL_W'(i % 4));
    end
    for (int i = 0; i < 8; i++) begin
      cyc();
    end
    in_valid = 4'b0000;
    settle();
    check("t2_xfer", {28'h0, xfer_count}, 32'd9);
    cyc();

    // Test 3: round-robin with only ch1 and ch3 valid
    in_valid = 4'b1010;
    begin
      logic [3:0] exp_rdy [3];
      logic [7:0] exp_dat [3];
      logic [2:0] exp_src [3];
      exp_rdy = '{4'b0010, 4'b1000, 4'b0010};
      exp_dat = '{8'h11, 8'h13, 8'h11};
      exp_src = '{3'd1, 3'd3, 3'd1};
      for (int i = 0; i < 3; i++) begin
        settle();
        check("t3_in_ready", {28'h0, in_ready}, {28'h0, exp_rdy[i]});
        push(exp_dat[i], exp_src[i]);
        cyc();
      end
    end
    in_valid = 4'b0000;
    settle();
    check("t3_xfer", {28'h0, xfer_count}, 32'd12);
    cyc();

    // Test 4: backpressure holds 3C for 5 cycles, then drain+load same edge
    mode      = 1'b0;
    sel       = 3'd0;
    in_valid  = 4'b0001;
    in_data   = {8'h13, 8'h12, 8'h11, 8'h3C};
    out_ready = 1'b0;
    settle();
    check("t4_load_ready", {28'h0, in_ready}, 32'h1);
    push(8'h3C, 3'd0);
    cyc();
    in_data  = {8'h13, 8'h12, 8'h11, 8'h5A};
    in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("t4_stall_in_ready", {28'h0, in_ready}, 32'h0);
      check("t4_stall_out_data", {24'h0, out_data}, 32'h3C);
      cyc();
    end
    out_ready = 1'b1;
    settle();
    check("t4_release_in_ready", {28'h0, in_ready}, 32'h1);
    push(8'h5A, 3'd0);
    cyc();

    // round-robin pointer untouched by fixed-mode transfers (still at ch2)
    mode = 1'b1;
    settle();
    check("t4_no_bubble_valid", {31'h0, out_valid},  32'h1);
    check("t4_xfer",            {28'h0, xfer_count}, 32'd14);
    check("rr_ptr_kept_ready",  {28'h0, in_ready},   32'h4);
    push(8'h12, 3'd2);
    cyc();

    // Test 5: sel out of range, then counter wrap
    mode = 1'b0;
    sel  = 3'd5;
    settle();
    check("t5_sel5_in_ready", {28'h0, in_ready}, 32'h0);
    cyc();
    settle();
    check("t5_sel5_out_valid", {31'h0, out_valid},  32'h0);
    check("t5_sel5_xfer",      {28'h0, xfer_count}, 32'd15);
    cyc();
    sel = 3'd1;
    settle();
    check("t5_sel1_in_ready", {28'h0, in_ready}, 32'h2);
    push(8'h11, 3'd1);
    cyc();
    in_valid = 4'b0000;
    settle();
    check("t5_wrap_xfer", {28'h0, xfer_count}, 32'd0);
    cyc();

    // Test 6: reset while holding a word, round-robin restarts at ch0
    out_ready = 1'b0;
    sel       = 3'd3;
    in_valid  = 4'b1000;
    cyc();
    in_valid = 4'b0000;
    settle();
    check("t6_held_valid", {31'h0, out_valid},  32'h1);
    check("t6_held_data",  {24'h0, out_data},   32'h13);
    check("t6_held_xfer",  {28'h0, xfer_count}, 32'd1);
    #2;
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #1;
    check("t6_rst_out_valid", {31'h0, out_valid},  32'h0);
    check("t6_rst_out_data",  {24'h0, out_data},   32'h0);
    check("t6_rst_out_src",   {29'h0, out_src},    32'h0);
    check("t6_rst_xfer",      {28'h0, xfer_count}, 32'h0);
    check("t6_rst_in_ready",  {28'h0, in_ready},   32'h0);
    cyc();
    cyc();
    rst_n = 1'b1;
    mode  = 1'b1;
    settle();
    check("t6_release_in_ready0", {28'h0, in_ready}, 32'h0);
    cyc();
    settle();
    check("t6_rr_restart_ch0", {28'h0, in_ready}, 32'h1);
    push(8'h5A, 3'd0);
    cyc();
    in_valid = 4'b0000;
    settle();
    check("t6_xfer", {28'h0, xfer_count}, 32'd1);
    cyc();
    cyc();
    settle();
    check("sb_empty", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
